// File: rtl/pet2001_ps2_pkg.sv
// Shared constants and types for the PS/2 to PET 2001 keyboard matrix bridge.
// Latency: n/a (declarations only); backpressure: n/a.
package pet2001_ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam int         KEY_ROWS  = 10;

    typedef struct packed {
        logic [3:0] row;
        logic [2:0] col;
    } key_pos_t;

endpackage

// File: rtl/pet2001_ps2_keymap.sv
// Set-2 scancode to PET matrix position lookup; hit=0 for codes with no PET key.
// Latency: combinational; backpressure: none.
module pet2001_ps2_keymap
    import pet2001_ps2_pkg::*;
(
    input  logic [7:0] code,
    output logic       hit,
    output key_pos_t   pos
);

    always_comb begin
        hit = 1'b1;
        pos = '0;
        case (code)
            8'h1C: pos = '{4'd4, 3'd0};   // A
            8'h32: pos = '{4'd6, 3'd2};   // B
            8'h21: pos = '{4'd6, 3'd1};   // C
            8'h23: pos = '{4'd4, 3'd1};   // D
            8'h24: pos = '{4'd2, 3'd1};   // E
            8'h2B: pos = '{4'd5, 3'd1};   // F
            8'h34: pos = '{4'd4, 3'd2};   // G
            8'h33: pos = '{4'd5, 3'd2};   // H
            8'h43: pos = '{4'd3, 3'd3};   // I
            8'h3B: pos = '{4'd4, 3'd3};   // J
            8'h42: pos = '{4'd5, 3'd3};   // K
            8'h4B: pos = '{4'd4, 3'd4};   // L
            8'h3A: pos = '{4'd6, 3'd3};   // M
            8'h31: pos = '{4'd7, 3'd2};   // N
            8'h44: pos = '{4'd2, 3'd4};   // O
            8'h4D: pos = '{4'd3, 3'd4};   // P
            8'h15: pos = '{4'd2, 3'd0};   // Q
            8'h2D: pos = '{4'd3, 3'd1};   // R
            8'h1B: pos = '{4'd5, 3'd0};   // S
            8'h2C: pos = '{4'd2, 3'd2};   // T
            8'h3C: pos = '{4'd2, 3'd3};   // U
            8'h2A: pos = '{4'd7, 3'd1};   // V
            8'h1D: pos = '{4'd3, 3'd0};   // W
            8'h22: pos = '{4'd7, 3'd0};   // X
            8'h35: pos = '{4'd3, 3'd2};   // Y
            8'h1A: pos = '{4'd6, 3'd0};   // Z
            // Top-row digits and keypad digits share the PET numeric keypad keys
            8'h45, 8'h70: pos = '{4'd8, 3'd6};
            8'h16, 8'h69: pos = '{4'd6, 3'd6};
            8'h1E, 8'h72: pos = '{4'd7, 3'd6};
            8'h26, 8'h7A: pos = '{4'd6, 3'd7};
            8'h25, 8'h6B: pos = '{4'd4, 3'd6};
            8'h2E, 8'h73: pos = '{4'd5, 3'd6};
            8'h36, 8'h74: pos = '{4'd4, 3'd7};
            8'h3D, 8'h6C: pos = '{4'd2, 3'd6};
            8'h3E, 8'h75: pos = '{4'd3, 3'd6};
            8'h46, 8'h7D: pos = '{4'd2, 3'd7};
            8'h29: pos = '{4'd9, 3'd2};   // space
            8'h5A: pos = '{4'd6, 3'd5};   // RETURN
            8'h12: pos = '{4'd8, 3'd0};   // left shift
            8'h59: pos = '{4'd8, 3'd5};   // right shift
            8'h66: pos = '{4'd1, 3'd7};   // backspace -> DEL
            8'h76: pos = '{4'd9, 3'd4};   // Esc -> STOP
            8'h0D: pos = '{4'd9, 3'd0};   // Tab -> RVS
            8'h55: pos = '{4'd9, 3'd7};   // =
            8'h4E: pos = '{4'd8, 3'd7};   // - (keypad minus position)
            8'h4A: pos = '{4'd3, 3'd7};   // /
            8'h4C: pos = '{4'd6, 3'd4};   // ;
            8'h41: pos = '{4'd7, 3'd3};   // ,
            8'h49: pos = '{4'd9, 3'd6};   // .
            8'h54: pos = '{4'd9, 3'd1};   // [
            8'h5B: pos = '{4'd8, 3'd2};   // ]
            8'h5D: pos = '{4'd1, 3'd3};   // backslash
            8'h52: pos = '{4'd1, 3'd2};   // '
            8'h0E: pos = '{4'd8, 3'd1};   // ` -> @
            8'h05: pos = '{4'd0, 3'd6};   // F1 -> HOME
            8'h06: pos = '{4'd0, 3'd7};   // F2 -> CRSR-RT
            8'h04: pos = '{4'd1, 3'd6};   // F3 -> CRSR-DN
            8'h0C: pos = '{4'd2, 3'd5};   // F4 -> ^
            8'h03: pos = '{4'd0, 3'd5};   // F5 -> <-
            8'h7C: pos = '{4'd5, 3'd7};   // keypad *
            8'h79: pos = '{4'd7, 3'd7};   // keypad +
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/pet2001_ps2_key.sv
// PS/2 keyboard to PET 2001 10x8 key matrix; define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
// Latency: matrix <=4 clk after stop-bit ps2_clk fall, keyin 1 clk after keyrow; backpressure: none.
module pet2001_ps2_key
    import pet2001_ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keyrow,
    output logic [7:0] keyin,
    input  logic       ps2_clk,
    input  logic       ps2_data
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]                      clk_sync;
    logic [1:0]                      dat_sync;
    logic                            ps2_fall;
    logic                            ps2_bit;
    logic [3:0]                      bit_cnt;
    logic [7:0]                      shreg;
    logic [TW-1:0]                   idle_cnt;
    logic                            frame_vld;
    logic                            parity_ok;
    logic                            map_hit;
    key_pos_t                        map_pos;
    logic                            brk_flag;
    logic                            ext_flag;
    logic [KEY_ROWS-1:0][7:0]        matrix;
    logic [7:0]                      row_dat;
`ifdef PS2_PARITY_CHECK_EN
    logic                            par_bit;
`endif

    // clk_sync[1] is the synchronised level, clk_sync[2] its previous value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign ps2_fall = clk_sync[2] & ~clk_sync[1];
    assign ps2_bit  = dat_sync[1];

    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        parity_ok = ^{par_bit, shreg};
`else
        parity_ok = 1'b1;
`endif
    end

    // bit_cnt: 0 waits for start, 1..8 data, 9 parity, 10 stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            idle_cnt  <= '0;
            frame_vld <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            frame_vld <= 1'b0;
            if (ps2_fall) begin
                idle_cnt <= '0;
                case (bit_cnt)
                    4'd0: if (!ps2_bit) bit_cnt <= 4'd1;
                    4'd9: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_bit <= ps2_bit;
`endif
                        bit_cnt <= 4'd10;
                    end
                    4'd10: begin
                        bit_cnt   <= '0;
                        frame_vld <= ps2_bit & parity_ok;
                    end
                    default: begin
                        shreg   <= {ps2_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                endcase
            end else if (bit_cnt != '0) begin
                if (idle_cnt == IDLE_MAX) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    // shreg is stable while frame_vld is high: it only shifts on data bits
    pet2001_ps2_keymap u_keymap (
        .code (shreg),
        .hit  (map_hit),
        .pos  (map_pos)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            matrix   <= '0;
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
        end else if (frame_vld) begin
            if (shreg == PS2_BREAK) begin
                brk_flag <= 1'b1;
            end else if (shreg == PS2_EXT) begin
                ext_flag <= 1'b1;
            end else begin
                if (!ext_flag && map_hit) matrix[map_pos.row][map_pos.col] <= ~brk_flag;
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        row_dat = 8'hFF;
        for (int r = 0; r < KEY_ROWS; r++) begin
            if (keyrow == 4'(r)) row_dat = ~matrix[r];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) keyin <= 8'hFF;
        else        keyin <= row_dat;
    end

endmodule

// File: tb/tb_pet2001_ps2_key.sv
// Bench for pet2001_ps2_key: directed PS/2 frames plus random scancode traffic against a key-set model.
module tb_pet2001_ps2_key;

    localparam int TO = 400;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [3:0] keyrow   = 4'd0;
    logic [7:0] keyin;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mrow [10];
    bit         brk;
    bit         ext;
    int         kmap [int];
    int         mapped_q [$];

    always #5 clk = ~clk;

    pet2001_ps2_key #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .keyrow   (keyrow),
        .keyin    (keyin),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    function automatic void add(input int code, input int row, input int col);
        kmap[code] = row * 8 + col;
        mapped_q.push_back(code);
    endfunction

    function automatic void init_map();
        add('h03,0,5); add('h05,0,6); add('h06,0,7);
        add('h52,1,2); add('h5D,1,3); add('h04,1,6); add('h66,1,7);
        add('h15,2,0); add('h24,2,1); add('h2C,2,2); add('h3C,2,3); add('h44,2,4); add('h0C,2,5);
        add('h3D,2,6); add('h6C,2,6); add('h46,2,7); add('h7D,2,7);
        add('h1D,3,0); add('h2D,3,1); add('h35,3,2); add('h43,3,3); add('h4D,3,4);
        add('h3E,3,6); add('h75,3,6); add('h4A,3,7);
        add('h1C,4,0); add('h23,4,1); add('h34,4,2); add('h3B,4,3); add('h4B,4,4);
        add('h25,4,6); add('h6B,4,6); add('h36,4,7); add('h74,4,7);
        add('h1B,5,0); add('h2B,5,1); add('h33,5,2); add('h42,5,3); add('h2E,5,6); add('h73,5,6); add('h7C,5,7);
        add('h1A,6,0); add('h21,6,1); add('h32,6,2); add('h3A,6,3); add('h4C,6,4); add('h5A,6,5);
        add('h16,6,6); add('h69,6,6); add('h26,6,7); add('h7A,6,7);
        add('h22,7,0); add('h2A,7,1); add('h31,7,2); add('h41,7,3); add('h1E,7,6); add('h72,7,6); add('h79,7,7);
        add('h12,8,0); add('h0E,8,1); add('h5B,8,2); add('h59,8,5); add('h45,8,6); add('h70,8,6); add('h4E,8,7);
        add('h0D,9,0); add('h54,9,1); add('h29,9,2); add('h76,9,4); add('h49,9,6); add('h55,9,7);
    endfunction

    function automatic void clear_model();
        for (int r = 0; r < 10; r++) mrow[r] = 8'h00;
        brk = 1'b0;
        ext = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int p;
        if (b == 8'hF0) brk = 1'b1;
        else if (b == 8'hE0) ext = 1'b1;
        else begin
            if (!ext && kmap.exists(int'(b))) begin
                p = kmap[int'(b)];
                mrow[p / 8][p % 8] = !brk;
            end
            brk = 1'b0;
            ext = 1'b0;
        end
    endfunction

    function automatic logic [7:0] exp_row(input int r);
        return (r < 10) ? ~mrow[r] : 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: keyin=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 16; r++) begin
            @(negedge clk) keyrow = 4'(r);
            @(negedge clk) chk($sformatf("%s row%0d", tag, r), keyin, exp_row(r));
        end
    endtask

    // One PS/2 bit; the final bit leaves ps2_clk low right after its falling edge
    task automatic ps2_bit(input logic b, input bit last);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        if (!last) begin
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
        ps2_bit((~^d) ^ par_flip, 1'b0);
        ps2_bit(stop, 1'b1);
    endtask

    task automatic bus_idle();
        repeat (10) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_code(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1);
        bus_idle();
        model_byte(d);
    endtask

    initial begin
        int k;
        int c;
        init_map();
        clear_model();

        repeat (5) @(negedge clk);
        chk("in_reset", keyin, 8'hFF);
        reset = 1'b1;
        check_all("idle");

        // Z make: keyin on row 6 must follow within 4+1 clk of the stop-bit fall
        @(negedge clk) keyrow = 4'd6;
        send_frame(8'h1A, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        model_byte(8'h1A);
        chk("latency_z", keyin, 8'hFE);
        bus_idle();
        check_all("z_held");
        send_code(8'hF0); send_code(8'h1A);
        check_all("z_released");

        send_code(8'h1A); send_code(8'h2C);
        check_all("z_t_held");
        send_code(8'h2C);
        check_all("t_typematic");
        send_code(8'hF0); send_code(8'h2C);
        check_all("t_released");
        send_code(8'hF0); send_code(8'h1A);
        check_all("all_released");
        send_code(8'hF0); send_code(8'h45);
        check_all("break_unheld");

        send_frame(8'h1A, 1'b1, 1'b1);
        bus_idle();
`ifndef PS2_PARITY_CHECK_EN
        model_byte(8'h1A);
`endif
        check_all("bad_parity");
        send_code(8'hF0); send_code(8'h1A);

        send_frame(8'h2C, 1'b0, 1'b0);
        bus_idle();
        check_all("bad_stop");

        send_code(8'hE0); send_code(8'h75);
        check_all("ext_ignored");
        send_code(8'h75);
        check_all("kp8_held");
        send_code(8'hF0); send_code(8'h75);

        // Partial frame then silence: receiver must realign on the next frame
        ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        repeat (TO + 50) @(negedge clk);
        send_code(8'h2C);
        check_all("after_timeout");
        send_code(8'hF0); send_code(8'h2C);

        for (int s = 0; s < 30; s++) begin
            k = $urandom_range(0, 9);
            c = mapped_q[$urandom_range(0, mapped_q.size() - 1)];
            if (k <= 5) send_code(8'(c));
            else if (k <= 7) begin send_code(8'hF0); send_code(8'(c)); end
            else if (k == 8) begin send_code(8'hE0); send_code(8'(c)); end
            else send_code(8'($urandom_range(0, 255)));
            check_all($sformatf("rand%0d", s));
        end

        send_code(8'h1A);
        ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_midframe", keyin, 8'hFF);
        reset = 1'b1;
        ps2_data = 1'b1;
        clear_model();
        check_all("post_reset");
        send_code(8'h1A);
        check_all("after_reset_z");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
